floating_point_to_integer: RTL and testbench
============================================

// Module: floating_point_to_integer
// PURPOSE
// - Multi-cycle converter: IEEE-style float (same format as floating_point_adder results) -> signed two's-complement integer.
// - Sits downstream of the FP arithmetic blocks; consumes their results via valid/ready; one conversion in flight.
// - Iterative: one left-shift of the significand per cycle, then one round/negate/range-check cycle.
// PARAMETERS
// - EXPONENT_WIDTH    8   float exponent width; bias = 2^(EXPONENT_WIDTH-1)-1
// - MANTISSA_WIDTH    23  float stored mantissa width (implicit leading 1 for normals)
// - INTEGER_WIDTH     32  result width, signed two's complement
// - ROUND_TO_NEAREST  1   1: round to nearest, ties to even; 0: truncate toward zero
// PORTS
// - clk                     in   1     single clock, all state on rising edge
// - rst                     in   1     synchronous reset, active-high
// - in_valid                in   1     float operand valid
// - in_ready                out  1     block idle, can accept
// - a                       in   E+M+1 float operand {sign, exponent, mantissa}
// - out_valid               out  1     result and flags valid
// - out_ready               in   1     consumer accepts result
// - out                     out  INTEGER_WIDTH  converted integer
// - overflow_flag           out  1     result saturated (inf or out of range)
// - invalid_operation_flag  out  1     operand was NaN (quiet or signaling)
// - inexact_flag            out  1     only with FP2INT_INEXACT_FLAG_EN
// BEHAVIOUR
// - Reset (rst=1 at edge): state=IDLE; out=0, out_valid=0, all flags=0; in_ready=1 from next cycle. Reset mid-conversion discards it.
// - in_ready = (state==IDLE). Accept when in_valid && in_ready. a is sampled only at accept.
// - Special detection via is_special_float (E4M3 encoding honoured: no infinity, all-ones NaN).
// - States: IDLE -> SHIFT -> ROUND -> DONE -> IDLE. Accept cycle = decode in IDLE; e = exponent - bias.
//   - NaN: out=-2^(W-1), invalid_operation_flag=1; IDLE->DONE.
//   - Inf or e >= INTEGER_WIDTH: out = sign ? -2^(W-1) : 2^(W-1)-1, overflow_flag=1; IDLE->DONE.
//   - Zero, subnormal, or e < -1: out=0; IDLE->DONE (|value| < 0.5 rounds to 0 in both modes).
//   - e == -1: fraction = 0.1m; round bit=1, sticky=|m; IDLE->ROUND.
//   - 0 <= e <= W-1: work register {1,m} with binary point above bit M-1; count=e; IDLE->SHIFT if e>0, else ->ROUND.
// - SHIFT: work <<= 1, count -= 1 each cycle; count reaches 0 -> ROUND. Max W-1 SHIFT cycles.
// - ROUND: int part = work[M+W-1:M]; round bit = work[M-1]; sticky = |work[M-2:0].
//   - RNE: increment if round && (sticky || int[0]). Truncate: never increment.
//   - Magnitude kept W+1 bits wide. Pos > 2^(W-1)-1 or neg > 2^(W-1): saturate as above, overflow_flag=1.
//   - Otherwise out = sign ? -mag : mag. -> DONE.
// - DONE: out_valid=1; out and flags stable until out_valid && out_ready, then IDLE (in_ready=1 next cycle).
// - Latency accept->out_valid: specials/zero/tiny = 1 cycle; normals = e+2 cycles (e=-1: 2); max W+1.
// - Back-to-back: no accept in the DONE handshake cycle; throughput >= 1 per latency+1 cycles.
// - Flags cleared at every accept; only meaningful while out_valid=1.
// CONFIGURATION
// - FP2INT_INEXACT_FLAG_EN defined: port inexact_flag present; =1 when any nonzero fraction bit was discarded
//   (round||sticky, nonzero subnormal, nonzero tiny value); 0 for NaN/overflow; reset 0, same timing as other flags.
// - Not defined: port and logic absent; all other behaviour identical.
// TESTING (defaults: E=8, M=23, W=32, RNE)
// - a=0x3F800000 (1.0) -> out=0x00000001, out_valid 2 cycles after accept, no flags.
// - 0x40600000 (3.5) -> 4; 0x40200000 (2.5) -> 2; 0xC0200000 (-2.5) -> 0xFFFFFFFE; ROUND_TO_NEAREST=0: 3.5 -> 3.
// - 0x4F32D05E (~3e9) -> 0x7FFFFFFF, overflow=1; 0xCF000000 (-2^31) -> 0x80000000, overflow=0, latency 33.
// - 0x7FC00000 (NaN) -> 0x80000000, invalid=1; 0xFF800000 (-inf) -> 0x80000000, overflow=1; latency 1.
// - out_ready low 5 cycles: out/flags stable, in_ready=0; rst during SHIFT -> out_valid=0, in_ready=1 next cycle.
// - 0x3ECCCCCD (0.4) -> 0; with FP2INT_INEXACT_FLAG_EN inexact_flag=1; 0x3F800000 -> inexact_flag=0.

Source files
------------

// File: rtl/floating_point_to_integer.sv
// Iterative float -> signed integer converter, one conversion in flight.
// Define FP2INT_INEXACT_FLAG_EN to add the inexact_flag output.
module floating_point_to_integer #(
    parameter int EXPONENT_WIDTH   = 8,
    parameter int MANTISSA_WIDTH   = 23,
    parameter int INTEGER_WIDTH    = 32,
    parameter int ROUND_TO_NEAREST = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [INTEGER_WIDTH-1:0]               out,
    output logic                                   overflow_flag,
    output logic                                   invalid_operation_flag
`ifdef FP2INT_INEXACT_FLAG_EN
    ,
    output logic                                   inexact_flag
`endif
);

    localparam int E    = EXPONENT_WIDTH;
    localparam int M    = MANTISSA_WIDTH;
    localparam int W    = INTEGER_WIDTH;
    localparam int CW   = $clog2(W);
    localparam int BIAS = (1 << (E - 1)) - 1;
    localparam bit IS_E4M3 = (E == 4) && (M == 3);
    localparam logic [W-1:0] INT_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] INT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W:0]   MAG_POS = {2'b00, {(W-1){1'b1}}};
    localparam logic [W:0]   MAG_NEG = {2'b01, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_n;

    logic [M+W-1:0] r_work;
    logic [CW-1:0]  r_cnt;
    logic           r_sign;
    logic           r_xs;
    logic [W-1:0]   r_out;
    logic           r_ovf;
    logic           r_inv;
`ifdef FP2INT_INEXACT_FLAG_EN
    logic           r_inx;
`endif

    logic               w_accept;
    logic               w_sign;
    logic [E-1:0]       w_exp;
    logic [M-1:0]       w_man;
    logic signed [31:0] w_e;
    logic               w_nan;
    logic               w_inf;
    logic               w_zsub;
    logic               w_big;
    logic               w_tiny;
    logic               w_half;
    logic               w_norm;

    logic [W-1:0] w_int;
    logic         w_rnd;
    logic         w_stk;
    logic         w_inc;
    logic [W:0]   w_mag;
    logic [W-1:0] w_neg;
    logic         w_rovf;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;
    assign out                    = r_out;
    assign overflow_flag          = r_ovf;
    assign invalid_operation_flag = r_inv;
`ifdef FP2INT_INEXACT_FLAG_EN
    assign inexact_flag           = r_inx;
`endif

    // Classify the operand into mutually exclusive conversion paths.
    always_comb begin
        w_sign = a[E+M];
        w_exp  = a[E+M-1:M];
        w_man  = a[M-1:0];
        w_e    = $signed({{(32-E){1'b0}}, w_exp}) - BIAS;
        w_zsub = (w_exp == '0);
        if (IS_E4M3) begin
            w_nan = (&w_exp) && (&w_man);
            w_inf = 1'b0;
        end else begin
            w_nan = (&w_exp) && (|w_man);
            w_inf = (&w_exp) && !(|w_man);
        end
        w_big  = !w_nan && (w_inf || (!w_zsub && (w_e >= W)));
        w_tiny = !w_nan && !w_big && (w_zsub || (w_e < -1));
        w_half = !w_nan && !w_big && !w_tiny && (w_e == -1);
        w_norm = !w_nan && !w_big && !w_tiny && !w_half;
    end

    // Round the shifted significand and check the signed range.
    always_comb begin
        w_int  = r_work[M+W-1:M];
        w_rnd  = r_work[M-1];
        w_stk  = (|r_work[M-2:0]) || r_xs;
        w_inc  = (ROUND_TO_NEAREST != 0) && w_rnd && (w_stk || w_int[0]);
        w_mag  = {1'b0, w_int} + {{W{1'b0}}, w_inc};
        w_neg  = '0 - w_mag[W-1:0];
        w_rovf = r_sign ? (w_mag > MAG_NEG) : (w_mag > MAG_POS);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    // Next-state logic.
    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_nan || w_big || w_tiny) w_state_n = S_DONE;
                    else if (w_half)              w_state_n = S_ROUND;
                    else if (w_e > 0)             w_state_n = S_SHIFT;
                    else                          w_state_n = S_ROUND;
                end
            end
            S_SHIFT: if (r_cnt == CW'(1)) w_state_n = S_ROUND;
            S_ROUND: w_state_n = S_DONE;
            S_DONE:  if (out_ready) w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    // Datapath: decode at accept, shift, then round into the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_xs   <= 1'b0;
            r_out  <= '0;
            r_ovf  <= 1'b0;
            r_inv  <= 1'b0;
`ifdef FP2INT_INEXACT_FLAG_EN
            r_inx  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_sign <= w_sign;
            r_ovf  <= 1'b0;
            r_inv  <= 1'b0;
            r_xs   <= 1'b0;
`ifdef FP2INT_INEXACT_FLAG_EN
            r_inx  <= 1'b0;
`endif
            unique case (1'b1)
                w_nan: begin
                    r_out <= INT_MIN;
                    r_inv <= 1'b1;
                end
                w_big: begin
                    r_out <= w_sign ? INT_MIN : INT_MAX;
                    r_ovf <= 1'b1;
                end
                w_tiny: begin
                    r_out <= '0;
`ifdef FP2INT_INEXACT_FLAG_EN
                    r_inx <= !(w_zsub && !(|w_man));
`endif
                end
                w_half: begin
                    r_work <= {{W{1'b0}}, 1'b1, w_man[M-1:1]};
                    r_xs   <= w_man[0];
                end
                w_norm: begin
                    r_work <= {{(W-1){1'b0}}, 1'b1, w_man};
                    r_cnt  <= w_e[CW-1:0];
                end
            endcase
        end else if (r_state == S_SHIFT) begin
            r_work <= {r_work[M+W-2:0], 1'b0};
            r_cnt  <= r_cnt - CW'(1);
        end else if (r_state == S_ROUND) begin
            if (w_rovf) begin
                r_out <= r_sign ? INT_MIN : INT_MAX;
                r_ovf <= 1'b1;
            end else begin
                r_out <= r_sign ? w_neg : w_mag[W-1:0];
            end
`ifdef FP2INT_INEXACT_FLAG_EN
            r_inx <= !w_rovf && (w_rnd || w_stk);
`endif
        end
    end

endmodule

// File: tb/tb_floating_point_to_integer.sv
// Directed-vector bench for floating_point_to_integer (RNE and truncate).
// Expected values are hand-computed for E=8, M=23, W=32.
module tb_floating_point_to_integer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        t_in_ready;
    logic [31:0] a;
    logic        out_valid;
    logic        t_out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [31:0] t_out;
    logic        ovf;
    logic        t_ovf;
    logic        inv;
    logic        t_inv;
`ifdef FP2INT_INEXACT_FLAG_EN
    logic        inx;
    logic        t_inx;
`endif

    int nvec;
    int nfail;

    floating_point_to_integer #(.ROUND_TO_NEAREST(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .overflow_flag(ovf), .invalid_operation_flag(inv)
`ifdef FP2INT_INEXACT_FLAG_EN
        , .inexact_flag(inx)
`endif
    );

    floating_point_to_integer #(.ROUND_TO_NEAREST(0)) dut_trn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .a(a), .out_valid(t_out_valid), .out_ready(out_ready), .out(t_out),
        .overflow_flag(t_ovf), .invalid_operation_flag(t_inv)
`ifdef FP2INT_INEXACT_FLAG_EN
        , .inexact_flag(t_inx)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] rne;
        logic [31:0] trn;
        bit          ovf;
        bit          inv;
        bit          inx;
        int          lat;
    } vec_t;

    vec_t vt[22];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int k;
        bit got;
        @(negedge clk);
        k = 0;
        while (!(in_ready && t_in_ready) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk($sformatf("v%0d_ready", id), {62'd0, in_ready, t_in_ready}, 64'd3);
        a = v.a;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            if (out_valid) got = 1'b1;
        end
        chk($sformatf("v%0d_lat", id), 64'(k), 64'(v.lat));
        chk($sformatf("v%0d_tvalid", id), {63'd0, t_out_valid}, 64'd1);
        chk($sformatf("v%0d_out", id), {32'd0, out}, {32'd0, v.rne});
        chk($sformatf("v%0d_tout", id), {32'd0, t_out}, {32'd0, v.trn});
        chk($sformatf("v%0d_ovf", id), {62'd0, ovf, t_ovf},
            {62'd0, v.ovf, v.ovf});
        chk($sformatf("v%0d_inv", id), {62'd0, inv, t_inv},
            {62'd0, v.inv, v.inv});
`ifdef FP2INT_INEXACT_FLAG_EN
        chk($sformatf("v%0d_inx", id), {62'd0, inx, t_inx},
            {62'd0, v.inx, v.inx});
`endif
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        int k;
        nvec      = 0;
        nfail     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 32'd0;

        //           a             rne           trn           ov iv ix lat
        vt[0]  = '{32'h3F800000, 32'h00000001, 32'h00000001, 0, 0, 0, 2};
        vt[1]  = '{32'h40600000, 32'h00000004, 32'h00000003, 0, 0, 1, 3};
        vt[2]  = '{32'h40200000, 32'h00000002, 32'h00000002, 0, 0, 1, 3};
        vt[3]  = '{32'hC0200000, 32'hFFFFFFFE, 32'hFFFFFFFE, 0, 0, 1, 3};
        vt[4]  = '{32'h4F32D05E, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 0, 0, 33};
        vt[5]  = '{32'hCF000000, 32'h80000000, 32'h80000000, 0, 0, 0, 33};
        vt[6]  = '{32'h7FC00000, 32'h80000000, 32'h80000000, 0, 1, 0, 1};
        vt[7]  = '{32'hFF800000, 32'h80000000, 32'h80000000, 1, 0, 0, 1};
        vt[8]  = '{32'h3ECCCCCD, 32'h00000000, 32'h00000000, 0, 0, 1, 1};
        vt[9]  = '{32'h3F000000, 32'h00000000, 32'h00000000, 0, 0, 1, 2};
        vt[10] = '{32'h3FC00000, 32'h00000002, 32'h00000001, 0, 0, 1, 2};
        vt[11] = '{32'h3F400000, 32'h00000001, 32'h00000000, 0, 0, 1, 2};
        vt[12] = '{32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 0, 1};
        vt[13] = '{32'h80000001, 32'h00000000, 32'h00000000, 0, 0, 1, 1};
        vt[14] = '{32'h4F000000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 0, 0, 33};
        vt[15] = '{32'h4F800000, 32'h7FFFFFFF, 32'h7FFFFFFF, 1, 0, 0, 1};
        vt[16] = '{32'h4EFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80, 0, 0, 0, 32};
        vt[17] = '{32'hBFC00000, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0, 1, 2};
        vt[18] = '{32'h7F800001, 32'h80000000, 32'h80000000, 0, 1, 0, 1};
        vt[19] = '{32'h447A0000, 32'h000003E8, 32'h000003E8, 0, 0, 0, 11};
        vt[20] = '{32'h3FE00000, 32'h00000002, 32'h00000001, 0, 0, 1, 2};
        vt[21] = '{32'h40100000, 32'h00000002, 32'h00000002, 0, 0, 1, 3};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out", {32'd0, out}, 64'd0);
        chk("rst_flags", {62'd0, ovf, inv}, 64'd0);
`ifdef FP2INT_INEXACT_FLAG_EN
        chk("rst_inx", {63'd0, inx}, 64'd0);
`endif

        for (int i = 0; i < 22; i++) run_vec(i, vt[i]);

        // Stall: result held while out_ready low, no accept meanwhile.
        @(negedge clk);
        a = 32'h40600000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 a = 32'h3F800000;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("stall_lat", 64'(k), 64'd3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_out", i), {32'd0, out}, 64'd4);
            chk($sformatf("stall%0d_hold", i), {62'd0, out_valid, in_ready},
                64'd2);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("dh_noaccept", {62'd0, out_valid, in_ready}, 64'd1);
        in_valid = 1'b0;

        // Reset in the middle of the SHIFT phase discards the conversion.
        @(negedge clk);
        a = 32'h447A0000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst", {62'd0, out_valid, in_ready}, 64'd1);
        chk("mid_out", {32'd0, out}, 64'd0);

        run_vec(99, vt[1]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
